id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and hazard unit. It sits on the consumer end of the instruction decoder's 10-bit control word. Each cycle it captures the decoded control bundle plus the register-file and immediate operands. It unpacks and sanitizes the control fields, detects load-use hazards, and inserts a one-cycle bubble with an IF/ID stall when one is found. It also honours EX back-pressure and branch flushes.

## Interface
Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst_n  in  1  asynchronous, active-low reset.
- control  in  10  decoder word: [9] regwrite, [8:5] alu_control, [4] alusrc, [3] memread, [2] memwrite, [1] branch, [0] memtoreg. Bit 0 may be X.
- if_id_valid  in  1  the IF/ID slot holds a real instruction.
- if_id_pc  in  XLEN  PC of the decoding instruction.
- rs1_addr, rs2_addr, rd_addr  in  5 each  register indices.
- rs1_data, rs2_data, imm  in  XLEN each  operands.
- flush  in  1  branch/jump resolved taken in EX; kill the instruction in ID.
- ex_ready  in  1  EX accepts the current ID/EX contents this cycle.
- id_ex_valid  out  1  the ID/EX slot holds a real instruction.
- id_ex_regwrite, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_branch, id_ex_memtoreg  out  1 each  registered control.
- id_ex_alu_control  out  4  registered ALU op.
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  XLEN each.
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each.
- id_ex_illegal  out  1  captured alu_control was 4'b1111.
- stall  out  1  combinational; hold the PC and IF/ID.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted, saturating.

## Operation
Combinational terms:
- Sanitized memtoreg = control[9] & control[3] & ~control[1]. Bit 0 is ignored, so X never propagates.
- rs2_used = ~control[4] | control[2].
- hazard = if_id_valid & id_ex_valid & id_ex_memread & ~id_ex_branch & (id_ex_rd != 0) & ((id_ex_rd == rs1_addr) | (rs2_used & (id_ex_rd == rs2_addr))).
- hold = id_ex_valid & ~ex_ready.
- stall = ~flush & (hold | hazard).

Register update on each rising edge, in priority order:
1. flush: id_ex_valid=0. All control outputs and id_ex_illegal are cleared to 0. Data fields don't-care. No bubble is counted.
2. hold: every output keeps its value.
3. hazard: bubble. id_ex_valid=0 and control outputs=0. bubble_cnt increments, saturating at all-ones. IF/ID is held by stall, so the same instruction is retried on the next cycle.
4. Otherwise load:
   - id_ex_valid = if_id_valid.
   - Control fields come from control. When if_id_valid=0, all control fields are forced to 0.
   - id_ex_illegal = if_id_valid & (control[8:5] == 4'b1111).
   - Data fields and addresses are copied from the inputs.

Rules:
- An empty slot never blocks: when id_ex_valid=0, the stage loads regardless of ex_ready.
- A hazard only occurs when the producer is a load. The jal/jalr/auipc encodings set memread=1 with branch=1; branch=1 excludes them.
- x0 as a destination never creates a hazard.

## Timing
- Reset (asynchronous assert, synchronous release): every output register is 0, id_ex_valid=0, bubble_cnt=0.
- stall is 0 during reset because id_ex_valid=0.
- Latency is one cycle from the ID inputs to the id_ex_* outputs.
- A load-use pair costs exactly one bubble cycle. In the cycle after the bubble the hazard term is false, because id_ex_valid=0, and the dependent instruction loads.
- Flush and hazard in the same cycle: flush wins. stall=0 and bubble_cnt is unchanged.
- Flush and hold in the same cycle: flush wins and the slot empties.
- Hold and hazard in the same cycle: hold wins. stall=1, nothing changes, and no bubble is counted that cycle.
- Reset asserted mid-hold or mid-bubble clears the stage immediately. It does not wait for a clock edge.

## Test plan
- Reset, then ADD: control=10'b1_0000_0_0_0_0_0 with rs1_data=5, rs2_data=7, rd=3. Next cycle: id_ex_valid=1, id_ex_regwrite=1, alu_control=0000, id_ex_rs1_data=5, id_ex_rs2_data=7, id_ex_rd=3, stall=0.
- Load-use: LW x5 (control=10'b1_0000_1_1_0_0_1), then ADD x6,x5,x1. The cycle after the LW loads: stall=1. Next edge: bubble (id_ex_valid=0), bubble_cnt=1. Following edge: the ADD is loaded.
- No false hazard:
  - LW x0 followed by a use of x0 → stall=0.
  - JAL (control=10'b1_0000_1_1_0_1_x) to rd=5, followed by a use of x5 → stall=0, and id_ex_memtoreg=0 (no X).
  - ADDI whose rs2 field equals the load's rd → stall=0.
- Back-pressure: hold ex_ready=0 for 3 cycles with a valid slot. Outputs stay frozen and stall=1 for all 3 cycles. When ex_ready=1, the new instruction loads on the next edge.
- Flush precedence: flush=1 in the same cycle as a load-use hazard → stall=0, id_ex_valid=0, bubble_cnt unchanged. Assert rst_n=0 mid-hold → all outputs are 0 immediately.
- Illegal op: R-type with funct3 decoding to alu_control=1111 → id_ex_illegal=1 with id_ex_valid=1. The same control word with if_id_valid=0 → id_ex_illegal=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard bubble, back-pressure hold and flush
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       control,
  input  logic             if_id_valid,
  input  logic [XLEN-1:0]  if_id_pc,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_ex_valid,
  output logic             id_ex_regwrite,
  output logic             id_ex_alusrc,
  output logic             id_ex_memread,
  output logic             id_ex_memwrite,
  output logic             id_ex_branch,
  output logic             id_ex_memtoreg,
  output logic [3:0]       id_ex_alu_control,
  output logic [XLEN-1:0]  id_ex_pc,
  output logic [XLEN-1:0]  id_ex_rs1_data,
  output logic [XLEN-1:0]  id_ex_rs2_data,
  output logic [XLEN-1:0]  id_ex_imm,
  output logic [4:0]       id_ex_rs1,
  output logic [4:0]       id_ex_rs2,
  output logic [4:0]       id_ex_rd,
  output logic             id_ex_illegal,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_cnt
);
  logic rs2_used, hazard, hold, memtoreg_s, unused_memtoreg_raw;
  assign unused_memtoreg_raw = control[0];
  // Hazard/hold detection; decoder memtoreg bit is rebuilt from regwrite/memread/branch so X never leaks
  always_comb begin
    memtoreg_s = control[9] & control[3] & ~control[1];
    rs2_used   = ~control[4] | control[2];
    hold       = id_ex_valid & ~ex_ready;
    hazard     = if_id_valid & id_ex_valid & id_ex_memread & ~id_ex_branch & (id_ex_rd != 5'd0) &
                 ((id_ex_rd == rs1_addr) | (rs2_used & (id_ex_rd == rs2_addr)));
    stall      = ~flush & (hold | hazard);
  end
  // Pipeline register: flush > hold > bubble > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_valid       <= 1'b0;
      id_ex_regwrite    <= 1'b0;
      id_ex_alusrc      <= 1'b0;
      id_ex_memread     <= 1'b0;
      id_ex_memwrite    <= 1'b0;
      id_ex_branch      <= 1'b0;
      id_ex_memtoreg    <= 1'b0;
      id_ex_alu_control <= 4'd0;
      id_ex_illegal     <= 1'b0;
      id_ex_pc          <= '0;
      id_ex_rs1_data    <= '0;
      id_ex_rs2_data    <= '0;
      id_ex_imm         <= '0;
      id_ex_rs1         <= 5'd0;
      id_ex_rs2         <= 5'd0;
      id_ex_rd          <= 5'd0;
      bubble_cnt        <= '0;
    end else if (flush || (!hold && hazard)) begin
      id_ex_valid       <= 1'b0;
      id_ex_regwrite    <= 1'b0;
      id_ex_alusrc      <= 1'b0;
      id_ex_memread     <= 1'b0;
      id_ex_memwrite    <= 1'b0;
      id_ex_branch      <= 1'b0;
      id_ex_memtoreg    <= 1'b0;
      id_ex_alu_control <= 4'd0;
      id_ex_illegal     <= 1'b0;
      bubble_cnt        <= flush ? bubble_cnt : bubble_cnt + CNT_W'(~&bubble_cnt);
    end else if (!hold) begin
      id_ex_valid       <= if_id_valid;
      id_ex_regwrite    <= if_id_valid & control[9];
      id_ex_alu_control <= if_id_valid ? control[8:5] : 4'd0;
      id_ex_alusrc      <= if_id_valid & control[4];
      id_ex_memread     <= if_id_valid & control[3];
      id_ex_memwrite    <= if_id_valid & control[2];
      id_ex_branch      <= if_id_valid & control[1];
      id_ex_memtoreg    <= if_id_valid & memtoreg_s;
      id_ex_illegal     <= if_id_valid & (control[8:5] == 4'b1111);
      id_ex_pc          <= if_id_pc;
      id_ex_rs1_data    <= rs1_data;
      id_ex_rs2_data    <= rs2_data;
      id_ex_imm         <= imm;
      id_ex_rs1         <= rs1_addr;
      id_ex_rs2         <= rs2_addr;
      id_ex_rd          <= rd_addr;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized check of id_ex_stage against a behavioural slot model
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [9:0] ADD  = 10'b1_0000_0_0_0_0_0;
  localparam logic [9:0] LW   = 10'b1_0000_1_1_0_0_1;
  localparam logic [9:0] ADDI = 10'b1_0000_1_0_0_0_0;
  localparam logic [9:0] ILL  = 10'b1_1111_0_0_0_0_0;
  logic clk = 0, rst_n = 0;
  logic [9:0] control = 0;
  logic if_id_valid = 0, flush = 0, ex_ready = 1;
  logic [XLEN-1:0] if_id_pc = 0, rs1_data = 0, rs2_data = 0, imm = 0;
  logic [4:0] rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
  logic id_ex_valid, id_ex_regwrite, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_branch, id_ex_memtoreg;
  logic [3:0] id_ex_alu_control;
  logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic id_ex_illegal, stall;
  logic [CW-1:0] bubble_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    bit valid, rw, as, mr, mw, br, mtr, ill;
    bit [3:0] alu;
    bit [31:0] pc, d1, d2, imm;
    bit [4:0] r1, r2, rd;
  } slot_t;
  slot_t m;
  int cnt;
  id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .control(control), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm), .flush(flush), .ex_ready(ex_ready), .id_ex_valid(id_ex_valid),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_alusrc(id_ex_alusrc), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_branch(id_ex_branch), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_alu_control(id_ex_alu_control), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
    .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_illegal(id_ex_illegal), .stall(stall), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask
  function automatic slot_t empty_slot(input slot_t s);
    slot_t r = s;
    r.valid = 0; r.rw = 0; r.as = 0; r.mr = 0; r.mw = 0; r.br = 0; r.mtr = 0; r.ill = 0; r.alu = 0;
    return r;
  endfunction
  // the consumer reads the register a pending load (not a jump) will write
  function automatic bit load_use();
    bit reads_rs2 = !control[4] || control[2];
    if (!(if_id_valid && m.valid && m.mr && !m.br) || m.rd == 0) return 0;
    return m.rd == rs1_addr || (reads_rs2 && m.rd == rs2_addr);
  endfunction
  function automatic bit exp_stall();
    return !flush && ((m.valid && !ex_ready) || load_use());
  endfunction
  task automatic model_edge();
    if (flush) m = empty_slot(m);
    else if (m.valid && !ex_ready) m = m;
    else if (load_use()) begin
      m = empty_slot(m);
      cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
    end else begin
      m = empty_slot(m);
      if (if_id_valid) begin
        m.valid = 1;
        m.rw = control[9]; m.alu = control[8:5]; m.as = control[4]; m.mr = control[3];
        m.mw = control[2]; m.br = control[1];
        m.mtr = control[9] && control[3] && !control[1];
        m.ill = control[8:5] == 4'hf;
      end
      m.pc = if_id_pc; m.d1 = rs1_data; m.d2 = rs2_data; m.imm = imm;
      m.r1 = rs1_addr; m.r2 = rs2_addr; m.rd = rd_addr;
    end
  endtask
  task automatic compare_model();
    chk("valid", id_ex_valid, m.valid);
    chk("regwrite", id_ex_regwrite, m.rw);
    chk("alu_control", id_ex_alu_control, m.alu);
    chk("alusrc", id_ex_alusrc, m.as);
    chk("memread", id_ex_memread, m.mr);
    chk("memwrite", id_ex_memwrite, m.mw);
    chk("branch", id_ex_branch, m.br);
    chk("memtoreg", id_ex_memtoreg, m.mtr);
    chk("illegal", id_ex_illegal, m.ill);
    chk("bubble_cnt", bubble_cnt, cnt);
    if (m.valid) begin
      chk("pc", id_ex_pc, m.pc);
      chk("rs1_data", id_ex_rs1_data, m.d1);
      chk("rs2_data", id_ex_rs2_data, m.d2);
      chk("imm", id_ex_imm, m.imm);
      chk("rs1", id_ex_rs1, m.r1);
      chk("rs2", id_ex_rs2, m.r2);
      chk("rd", id_ex_rd, m.rd);
    end
  endtask
  task automatic cycle();
    #2 chk("stall", stall, exp_stall());
    @(posedge clk);
    model_edge();
    #1 compare_model();
  endtask
  task automatic ins(input logic [9:0] c, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic [31:0] d1, input logic [31:0] d2);
    control = c; rs1_addr = r1; rs2_addr = r2; rd_addr = rd; rs1_data = d1; rs2_data = d2;
    imm = d1 ^ d2; if_id_pc = if_id_pc + 4; if_id_valid = 1; flush = 0; ex_ready = 1;
  endtask
  task automatic check_cleared(input string n);
    chk({n, "_outs"}, {id_ex_valid, id_ex_regwrite, id_ex_alusrc, id_ex_memread, id_ex_memwrite,
        id_ex_branch, id_ex_memtoreg, id_ex_alu_control, id_ex_illegal, stall, bubble_cnt}, 0);
    chk({n, "_data"}, {id_ex_pc, id_ex_rs1_data}, 0);
    chk({n, "_data2"}, {id_ex_rs2_data, id_ex_imm}, 0);
    chk({n, "_regs"}, {id_ex_rs1, id_ex_rs2, id_ex_rd}, 0);
  endtask
  initial begin
    m = empty_slot(m);
    m.pc = 0; m.d1 = 0; m.d2 = 0; m.imm = 0; m.r1 = 0; m.r2 = 0; m.rd = 0;
    cnt = 0;
    #12 check_cleared("reset");
    @(negedge clk) rst_n = 1;
    ins(ADD, 1, 2, 3, 5, 7);
    cycle();
    chk("add_valid", id_ex_valid, 1);
    chk("add_regwrite", id_ex_regwrite, 1);
    chk("add_alu", id_ex_alu_control, 0);
    chk("add_rs1_data", id_ex_rs1_data, 5);
    chk("add_rs2_data", id_ex_rs2_data, 7);
    chk("add_rd", id_ex_rd, 3);
    ins(LW, 1, 0, 5, 100, 0);
    #1 chk("add_stall", stall, 0);
    cycle();
    ins(ADD, 5, 1, 6, 8, 9);
    #1 chk("lu_stall", stall, 1);
    cycle();
    chk("lu_bubble_valid", id_ex_valid, 0);
    chk("lu_bubble_cnt", bubble_cnt, 1);
    #1 chk("lu_after_stall", stall, 0);
    cycle();
    chk("lu_add_loaded", {id_ex_valid, id_ex_rd}, {1'b1, 5'd6});
    ins(LW, 2, 0, 0, 1, 2);
    cycle();
    ins(ADD, 0, 0, 4, 1, 1);
    #1 chk("x0_stall", stall, 0);
    cycle();
    ins(10'b1_0000_1_1_0_1_x, 0, 0, 5, 3, 3);
    cycle();
    chk("jal_memtoreg", id_ex_memtoreg, 0);
    ins(ADD, 5, 5, 7, 4, 4);
    #1 chk("jal_stall", stall, 0);
    cycle();
    ins(LW, 1, 0, 7, 1, 1);
    cycle();
    ins(ADDI, 1, 7, 8, 2, 2);
    #1 chk("addi_stall", stall, 0);
    cycle();
    ins(ADD, 2, 3, 9, 11, 12);
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", stall, 1);
      cycle();
      chk("bp_frozen", {id_ex_valid, id_ex_rd, id_ex_rs1_data}, {1'b1, 5'd8, 32'd2});
    end
    ex_ready = 1;
    cycle();
    chk("bp_release", {id_ex_rd, id_ex_rs1_data}, {5'd9, 32'd11});
    ins(LW, 1, 0, 4, 1, 1);
    cycle();
    ins(ADD, 4, 1, 5, 1, 1);
    flush = 1;
    #1 chk("flush_stall", stall, 0);
    cycle();
    chk("flush_valid", id_ex_valid, 0);
    chk("flush_cnt", bubble_cnt, 1);
    ins(ILL, 1, 2, 3, 1, 1);
    cycle();
    chk("ill_set", {id_ex_illegal, id_ex_valid}, 2'b11);
    if_id_valid = 0;
    cycle();
    chk("ill_invalid", id_ex_illegal, 0);
    ins(ADD, 1, 2, 3, 21, 22);
    cycle();
    ex_ready = 0;
    cycle();
    #3 rst_n = 0;
    #1 check_cleared("rst_hold");
    m = empty_slot(m);
    m.pc = 0; m.d1 = 0; m.d2 = 0; m.imm = 0; m.r1 = 0; m.r2 = 0; m.rd = 0;
    cnt = 0;
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      control = 10'($urandom);
      if_id_valid = $urandom_range(0, 4) != 0;
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      rd_addr = 5'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; if_id_pc = $urandom;
      flush = $urandom_range(0, 9) == 0;
      ex_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    chk("bubble_saturated", bubble_cnt, CMAX);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
